serial_paralelo: RTL and testbench



---
 rtl/serial_paralelo.sv | 144 ++++++++++++++
 tb/tb_serial_paralelo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo.sv
// rtl/serial_paralelo.sv - serial-to-parallel byte deserializer with comma-based byte alignment
//
// Purpose:
//   Shifts a serial bit stream (MSB first) into a byte register, locks byte
//   alignment after SYNC_COUNT consecutive aligned COM characters, then
//   presents every non-COM byte on data_out for one full byte slot.
//
// Ports:
//   clk_32f    in   1  bit clock, all state changes on its rising edge
//   reset      in   1  asynchronous, active-low reset
//   data_in    in   1  serial data, MSB of each byte first
//   data_out   out  8  last received non-COM byte (registered)
//   valid_out  out  1  data_out holds the byte of the current slot (registered)
//   active     out  1  byte alignment achieved (registered)

module serial_paralelo #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int BCW = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_sr;
    logic [7:0]     w_sr_next;
    logic [2:0]     r_bit_cnt;
    logic [2:0]     w_bit_cnt_next;
    logic [BCW-1:0] r_bc_cnt;
    logic [BCW-1:0] w_bc_cnt_next;
    logic [BCW-1:0] w_bc_inc;
    logic [7:0]     r_data_out;
    logic [7:0]     w_data_next;
    logic           r_valid;
    logic           w_valid_next;
    logic           r_active;
    logic           w_active_next;
    logic           w_is_com;
    logic           w_boundary;

    // The byte under test always includes the bit arriving this cycle, so
    // outputs update on the same edge that samples the LSB.
    assign w_sr_next  = {r_sr[6:0], data_in};
    assign w_is_com   = (w_sr_next == COM);
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_bc_inc   = r_bc_cnt + BCW'(1);

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt + 3'd1;
        w_bc_cnt_next  = r_bc_cnt;
        w_data_next    = r_data_out;
        w_valid_next   = r_valid;
        w_active_next  = r_active;

        case (r_state)
            SEARCH: begin
                // Bit-by-bit hunt; the COM just found is the first of the run.
                w_bit_cnt_next = 3'd0;
                w_valid_next   = 1'b0;
                w_bc_cnt_next  = '0;
                if (w_is_com) begin
                    w_bc_cnt_next = BCW'(1);
                    if (SYNC_COUNT <= 1) begin
                        w_state_next  = ACTIVE;
                        w_active_next = 1'b1;
                    end else begin
                        w_state_next = ALIGN;
                    end
                end
            end
            ALIGN: begin
                w_valid_next = 1'b0;
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_bc_cnt_next = w_bc_inc;
                        if (w_bc_inc == BCW'(SYNC_COUNT)) begin
                            w_state_next  = ACTIVE;
                            w_active_next = 1'b1;
                        end
                    end else begin
                        // The failing byte is dropped; the hunt resumes with
                        // the next bit.
                        w_state_next  = SEARCH;
                        w_bc_cnt_next = '0;
                    end
                end
            end
            ACTIVE: begin
                // Only byte boundaries are inspected, so a COM pattern
                // straddling two bytes cannot shift the alignment.
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_valid_next = 1'b0;
                    end else begin
                        w_data_next  = w_sr_next;
                        w_valid_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state    <= SEARCH;
            r_sr       <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_bc_cnt   <= '0;
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sr       <= w_sr_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_bc_cnt   <= w_bc_cnt_next;
            r_data_out <= w_data_next;
            r_valid    <= w_valid_next;
            r_active   <= w_active_next;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign active    = r_active;

endmodule

// File: tb/tb_serial_paralelo.sv
// tb/tb_serial_paralelo.sv - self-checking bench for serial_paralelo

module tb_serial_paralelo;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         SC  = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int total = 0;
    int bad   = 0;

    bit         hist[$];
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;

    serial_paralelo #(.COM(COM), .SYNC_COUNT(SC)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Eight bits of history ending at sample t; samples before reset release read as 0.
    function automatic logic [7:0] win(input int t);
        logic [7:0] w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int idx = t - 7 + i;
            w = {w[6:0], (idx >= 0) ? logic'(hist[idx]) : 1'b0};
        end
        return w;
    endfunction

    // Replays the whole post-reset bit history: find a COM window, require
    // SC-1 further COMs on 8-bit steps, otherwise resume one bit past the
    // failing byte; once locked, every later 8-bit step is a byte slot.
    function automatic void model();
        int n = hist.size();
        int t = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
        while (t < n) begin
            int fail = -1;
            bit pending = 1'b0;
            if (win(t) != COM) begin
                t++;
                continue;
            end
            for (int k = 1; k < SC; k++) begin
                int b = t + 8 * k;
                if (b >= n) begin
                    pending = 1'b1;
                    break;
                end
                if (win(b) != COM) begin
                    fail = b;
                    break;
                end
            end
            if (pending) return;
            if (fail >= 0) begin
                t = fail + 1;
                continue;
            end
            m_active = 1'b1;
            for (int b = t + 8 * SC; b < n; b += 8) begin
                if (win(b) != COM) begin
                    m_data  = win(b);
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            return;
        end
    endfunction

    always @(posedge clk_32f) begin
        if (reset) hist.push_back(data_in);
        else       hist.delete();
        #1;
        model();
        chk("cyc_active", {7'd0, active}, {7'd0, m_active});
        chk("cyc_valid", {7'd0, valid_out}, {7'd0, m_valid});
        chk("cyc_data", data_out, m_data);
    end

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7 - i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 8);
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset   = 1'b0;
        data_in = 1'b0;
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk_32f);
        chk("rst_active", {7'd0, active}, 8'd0);
        chk("rst_valid", {7'd0, valid_out}, 8'd0);
        chk("rst_data", data_out, 8'h00);
        reset = 1'b1;

        // Basic lock then two data bytes.
        repeat (3) send_byte(COM);
        send_bits(COM, 7);
        chk("lock_before_lsb", {7'd0, active}, 8'd0);
        send_bit(1'b0);
        chk("lock_at_lsb", {7'd0, active}, 8'd1);
        chk("lock_valid", {7'd0, valid_out}, 8'd0);
        send_byte(8'hA5);
        chk("a5_data", data_out, 8'hA5);
        chk("a5_valid", {7'd0, valid_out}, 8'd1);
        send_bits(8'h3C, 7);
        chk("a5_hold", data_out, 8'hA5);
        send_bit(1'b0);
        chk("3c_data", data_out, 8'h3C);

        // Data, two idles, data.
        send_byte(8'h55);
        chk("55_valid", {7'd0, valid_out}, 8'd1);
        send_byte(COM);
        chk("idle1_valid", {7'd0, valid_out}, 8'd0);
        chk("idle1_data", data_out, 8'h55);
        send_byte(COM);
        chk("idle2_data", data_out, 8'h55);
        send_byte(8'h0F);
        chk("0f_data", data_out, 8'h0F);
        chk("0f_valid", {7'd0, valid_out}, 8'd1);

        // 5E followed by 21 contains BC across the boundary.
        send_byte(8'h5E);
        chk("5e_data", data_out, 8'h5E);
        send_byte(8'h21);
        chk("21_data", data_out, 8'h21);
        chk("21_valid", {7'd0, valid_out}, 8'd1);

        // Reset mid-byte while active.
        send_bits(8'hA5, 3);
        @(negedge clk_32f);
        reset = 1'b0;
        #1;
        chk("async_active", {7'd0, active}, 8'd0);
        chk("async_valid", {7'd0, valid_out}, 8'd0);
        chk("async_data", data_out, 8'h00);
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
        repeat (3) send_byte(COM);
        chk("relock_3", {7'd0, active}, 8'd0);
        send_byte(COM);
        chk("relock_4", {7'd0, active}, 8'd1);

        // Broken sync run.
        do_reset();
        repeat (3) send_byte(COM);
        send_byte(8'h12);
        chk("break_active", {7'd0, active}, 8'd0);
        repeat (4) send_byte(COM);
        chk("break_relock", {7'd0, active}, 8'd1);
        send_byte(8'h77);
        chk("77_data", data_out, 8'h77);

        // Three garbage bits ahead of the sync run.
        do_reset();
        send_bits(8'b1010_0000, 3);
        repeat (4) send_byte(COM);
        chk("garb_active", {7'd0, active}, 8'd1);
        send_byte(8'hFF);
        chk("ff_data", data_out, 8'hFF);
        chk("ff_valid", {7'd0, valid_out}, 8'd1);

        // Randomized streams checked cycle by cycle against the model.
        for (int run = 0; run < 10; run++) begin
            do_reset();
            send_bits(8'($urandom), int'($urandom_range(0, 8)));
            repeat ($urandom_range(2, 5)) send_byte(COM);
            for (int j = 0; j < 24; j++) begin
                if ($urandom_range(0, 3) == 0) send_byte(COM);
                else send_byte(8'($urandom));
                if ($urandom_range(0, 15) == 0) send_bit(1'($urandom));
                if (run == 5 && j == 10) begin
                    send_bits(8'($urandom), 4);
                    do_reset();
                    repeat (4) send_byte(COM);
                end
            end
        end

        // Pure noise.
        do_reset();
        for (int i = 0; i < 200; i++) send_bit(1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
